// File: rtl/timer_delay_sched_if.sv
// Avalon-MM write-only link between the delay scheduler and the shared interval timer.
// The scheduler is the master; the timer only returns its IRQ level.
interface timer_delay_sched_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_delay_sched.sv
// Shares one interval timer among NUM_REQ one-shot delay requesters, granting round-robin
// and programming/clearing the timer itself so no CPU is involved in hardware waits.
module timer_delay_sched #(
    parameter int          NUM_REQ    = 4,
    parameter logic [15:0] CTRL_START = 16'h0005,
    parameter logic [15:0] CTRL_STOP  = 16'h0008
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  delay,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [2:0]             active_id,
    timer_delay_sched_if.master    tmr
);

    typedef enum logic [3:0] {
        INIT_STOP,
        INIT_CLR,
        IDLE,
        WR_PL,
        WR_PH,
        GAP,
        WR_CTRL,
        WAIT_IRQ,
        CLR,
        DONE,
        CANCEL_STOP,
        CANCEL_CLR
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 init_landed;
    logic [2:0]           owner;
    logic [2:0]           next_owner;
    logic [2:0]           last_owner;
    logic [31:0]          delay_q;
    logic [31:0]          next_delay;
    logic                 grant_valid;
    logic [2:0]           grant_id;
    logic [31:0]          grant_delay;
    logic                 owner_req;
    logic [NUM_REQ-1:0]   next_done;
    logic                 next_cs;
    logic                 next_write_n;
    logic [2:0]           next_addr;
    logic [15:0]          next_data;

    assign active_id = owner;

    // Round-robin search: the first requester at or after last_owner+1 wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && req[i] && (i == (int'(last_owner) + 1 + k) % NUM_REQ)) begin
                    grant_valid = 1'b1;
                    grant_id    = 3'(i);
                end
            end
        end
    end

    always_comb begin
        grant_delay = '0;
        owner_req   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == grant_id) grant_delay = delay[32*i +: 32];
            if (3'(i) == owner)    owner_req   = req[i];
        end
    end

    // INIT_STOP holds for one extra cycle after reset release so its stop write is actually
    // driven on the bus; all outputs are reset-quiet while reset is asserted.
    always_comb begin
        next_state = state;
        next_owner = owner;
        next_delay = delay_q;
        case (state)
            INIT_STOP:   next_state = init_landed ? INIT_CLR : INIT_STOP;
            INIT_CLR:    next_state = IDLE;
            IDLE: begin
                if (grant_valid) begin
                    next_owner = grant_id;
                    next_delay = grant_delay;
                    next_state = (grant_delay == 32'd0) ? DONE : WR_PL;
                end
            end
            WR_PL:       next_state = WR_PH;
            WR_PH:       next_state = GAP;
            GAP:         next_state = WR_CTRL;
            WR_CTRL:     next_state = WAIT_IRQ;
            WAIT_IRQ: begin
                if (tmr.tmr_irq)     next_state = CLR;
                else if (!owner_req) next_state = CANCEL_STOP;
            end
            CLR:         next_state = DONE;
            DONE:        next_state = IDLE;
            CANCEL_STOP: next_state = CANCEL_CLR;
            CANCEL_CLR:  next_state = IDLE;
            default:     next_state = INIT_STOP;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so they line up with it.
    always_comb begin
        next_cs      = 1'b0;
        next_write_n = 1'b1;
        next_addr    = 3'd0;
        next_data    = 16'd0;
        next_done    = '0;
        case (next_state)
            INIT_STOP, CANCEL_STOP: begin
                next_cs      = 1'b1;
                next_write_n = 1'b0;
                next_addr    = 3'd1;
                next_data    = CTRL_STOP;
            end
            INIT_CLR, CLR, CANCEL_CLR: begin
                next_cs      = 1'b1;
                next_write_n = 1'b0;
            end
            WR_PL: begin
                next_cs      = 1'b1;
                next_write_n = 1'b0;
                next_addr    = 3'd2;
                next_data    = next_delay[15:0];
            end
            WR_PH: begin
                next_cs      = 1'b1;
                next_write_n = 1'b0;
                next_addr    = 3'd3;
                next_data    = next_delay[31:16];
            end
            WR_CTRL: begin
                next_cs      = 1'b1;
                next_write_n = 1'b0;
                next_addr    = 3'd1;
                next_data    = CTRL_START;
            end
            DONE:    next_done = NUM_REQ'(1) << next_owner;
            default: next_cs   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= INIT_STOP;
            init_landed        <= 1'b0;
            owner              <= '0;
            last_owner         <= 3'(NUM_REQ - 1);
            delay_q            <= '0;
            done               <= '0;
            busy               <= 1'b1;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_address    <= 3'd0;
            tmr.tmr_writedata  <= 16'd0;
        end else begin
            state              <= next_state;
            init_landed        <= 1'b1;
            owner              <= next_owner;
            delay_q            <= next_delay;
            if (state == DONE || state == CANCEL_CLR) last_owner <= owner;
            done               <= next_done;
            busy               <= (next_state != IDLE);
            tmr.tmr_chipselect <= next_cs;
            tmr.tmr_write_n    <= next_write_n;
            tmr.tmr_address    <= next_addr;
            tmr.tmr_writedata  <= next_data;
        end
    end

endmodule

// File: tb/tb_timer_delay_sched.sv
// Randomized bench for timer_delay_sched against a behavioural interval-timer model and a
// scoreboard that predicts grant order, bus writes and done latency from the block's rules.
module tb_timer_delay_sched;
    localparam int NUM_REQ = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] delay;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;
    logic [2:0]            active_id;

    timer_delay_sched_if tmr();

    timer_delay_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .delay     (delay),
        .done      (done),
        .busy      (busy),
        .active_id (active_id),
        .tmr       (tmr)
    );

    always #5 clk = ~clk;

    // Interval timer: counts period..0, sets timeout on expiry, one-shot unless CONT.
    // It has no tie to reset_n; only the scheduler's own writes stop and clear it.
    logic [31:0] t_period  = '0;
    logic [31:0] t_count   = '0;
    logic        t_run     = 1'b0;
    logic        t_timeout = 1'b0;
    logic        t_ito     = 1'b0;
    logic        t_cont    = 1'b0;

    always @(posedge clk) begin
        if (t_run) begin
            if (t_count == 32'd0) begin
                t_timeout <= 1'b1;
                t_count   <= t_period;
                if (!t_cont) t_run <= 1'b0;
            end else begin
                t_count <= t_count - 32'd1;
            end
        end
        if (tmr.tmr_chipselect && !tmr.tmr_write_n) begin
            case (tmr.tmr_address)
                3'd0: t_timeout <= 1'b0;
                3'd1: begin
                    t_ito  <= tmr.tmr_writedata[0];
                    t_cont <= tmr.tmr_writedata[1];
                    if (tmr.tmr_writedata[3])      t_run <= 1'b0;
                    else if (tmr.tmr_writedata[2]) t_run <= 1'b1;
                end
                3'd2: begin
                    t_period[15:0] <= tmr.tmr_writedata;
                    t_count        <= {t_period[31:16], tmr.tmr_writedata};
                end
                3'd3: begin
                    t_period[31:16] <= tmr.tmr_writedata;
                    t_count         <= {tmr.tmr_writedata, t_period[15:0]};
                end
                default: ;
            endcase
        end
    end

    assign tmr.tmr_irq = t_timeout & t_ito;

    int          checks      = 0;
    int          errors      = 0;
    int          cyc         = 0;
    int          done_pulses = 0;
    int          irq_cycles  = 0;
    int          last_own    = NUM_REQ - 1;
    logic        busy_prev   = 1'b1;
    logic        rose        = 1'b0;
    logic [31:0] wr_log[$];
    logic [31:0] exp_wr[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step_cycle();
        @(negedge clk);
        cyc++;
        if (tmr.tmr_chipselect && !tmr.tmr_write_n)
            wr_log.push_back({13'd0, tmr.tmr_address, tmr.tmr_writedata});
        if (done != '0) done_pulses++;
        if (tmr.tmr_irq) irq_cycles++;
        rose      = busy && !busy_prev;
        busy_prev = busy;
    endtask

    function automatic logic [31:0] wr_entry(input logic [2:0] a, input logic [15:0] d);
        return {13'd0, a, d};
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] pend, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic expect_setup_writes(input logic [31:0] d);
        exp_wr.delete();
        if (d != 32'd0) begin
            exp_wr.push_back(wr_entry(3'd2, d[15:0]));
            exp_wr.push_back(wr_entry(3'd3, d[31:16]));
            exp_wr.push_back(wr_entry(3'd1, 16'h0005));
        end
    endtask

    task automatic check_writes(input string tag);
        checkOutput({tag, "_count"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            checkOutput(tag, wr_log[i], exp_wr[i]);
    endtask

    task automatic check_reset_values();
        checkOutput("rst_busy",      busy,               1);
        checkOutput("rst_done",      done,               0);
        checkOutput("rst_active_id", active_id,          0);
        checkOutput("rst_cs",        tmr.tmr_chipselect, 0);
        checkOutput("rst_write_n",   tmr.tmr_write_n,    1);
        checkOutput("rst_addr",      tmr.tmr_address,    0);
        checkOutput("rst_data",      tmr.tmr_writedata,  0);
    endtask

    // Called at the negedge where reset_n was just released, with req low.
    task automatic check_init_sequence();
        int done_before;
        int cs_late;
        done_before = done_pulses;
        cs_late     = 0;
        wr_log.delete();
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            if (k <= 2) checkOutput("init_busy_high", busy, 1);
            if (k == 3) checkOutput("init_busy_low", busy, 0);
            if (k >= 3 && tmr.tmr_chipselect) cs_late++;
        end
        exp_wr.delete();
        exp_wr.push_back(wr_entry(3'd1, 16'h0008));
        exp_wr.push_back(wr_entry(3'd0, 16'h0000));
        check_writes("init_writes");
        checkOutput("init_cs_quiet", cs_late, 0);
        checkOutput("init_no_done", done_pulses - done_before, 0);
        last_own = NUM_REQ - 1;
    endtask

    // Requesters in mask hold req until their done, then drop it; the scoreboard predicts the
    // owner of every grant, its bus writes and the done latency.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [32*NUM_REQ-1:0] dvec,
                                 input int budget);
        logic [NUM_REQ-1:0] pend;
        logic [31:0]        d;
        int                 cur;
        int                 grant_cyc;
        int                 lat;
        int                 guard;
        pend      = mask;
        cur       = 0;
        grant_cyc = 0;
        guard     = 0;
        delay     = dvec;
        req       = mask;
        wr_log.delete();
        while ((pend != '0 || busy) && guard < budget) begin
            step_cycle();
            guard++;
            if (rose) begin
                cur = rr_pick(pend, last_own);
                checkOutput("grant_id", active_id, cur);
                grant_cyc = cyc - 1;
            end
            if (done != '0) begin
                d = dvec[32*cur +: 32];
                checkOutput("done_owner", done, 32'd1 << cur);
                lat = cyc - grant_cyc;
                if (d == 32'd0) checkOutput("latency_zero", lat, 1);
                else checkOutput("latency_window", (lat >= int'(d) + 7 && lat <= int'(d) + 9), 1);
                expect_setup_writes(d);
                if (d != 32'd0) exp_wr.push_back(wr_entry(3'd0, 16'h0000));
                check_writes("grant_writes");
                wr_log.delete();
                pend[cur] = 1'b0;
                req[cur]  = 1'b0;
                last_own  = cur;
            end
        end
        checkOutput("batch_complete", {busy, pend}, 0);
    endtask

    task automatic run_cancel(input int id, input logic [31:0] d, input int drop_at);
        int   grant_cyc;
        int   guard;
        int   done_before;
        int   irq_before;
        logic granted;
        grant_cyc   = 0;
        guard       = 0;
        granted     = 1'b0;
        done_before = done_pulses;
        delay[32*id +: 32] = d;
        req     = '0;
        req[id] = 1'b1;
        wr_log.delete();
        while (guard < 5000) begin
            step_cycle();
            guard++;
            if (rose) begin
                checkOutput("cancel_grant", active_id, id);
                grant_cyc = cyc - 1;
                granted   = 1'b1;
            end
            if (granted && cyc - grant_cyc == drop_at) req[id] = 1'b0;
            if (granted && !busy) break;
        end
        checkOutput("cancel_idle", {granted, busy}, 2'b10);
        expect_setup_writes(d);
        exp_wr.push_back(wr_entry(3'd1, 16'h0008));
        exp_wr.push_back(wr_entry(3'd0, 16'h0000));
        check_writes("cancel_writes");
        irq_before = irq_cycles;
        repeat (1500) step_cycle();
        checkOutput("cancel_no_done", done_pulses - done_before, 0);
        checkOutput("cancel_irq_quiet", irq_cycles - irq_before, 0);
        last_own = id;
    endtask

    initial begin
        logic [32*NUM_REQ-1:0] dv;
        logic [NUM_REQ-1:0]    mask;
        int                    guard;
        int                    done_before;

        reset_n = 1'b0;
        req     = '0;
        delay   = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        check_init_sequence();

        dv = {NUM_REQ{32'd20}};
        applyStimulus(4'b1111, dv, 2000);

        dv = '0;
        dv[63:32] = 32'h0001_0005;
        applyStimulus(4'b0010, dv, 70000);

        dv = '0;
        applyStimulus(4'b0100, dv, 100);

        run_cancel(0, 32'd1000, 100);

        for (int b = 0; b < 8; b++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++)
                dv[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
            applyStimulus(mask, dv, 3000);
            repeat ($urandom_range(0, 3)) step_cycle();
        end

        // Reset while the owner is waiting on the timer IRQ.
        dv = '0;
        dv[32*3 +: 32] = 32'd500;
        delay = dv;
        req   = 4'b1000;
        done_before = done_pulses;
        guard = 0;
        while (!busy && guard < 50) begin
            step_cycle();
            guard++;
        end
        repeat (40) step_cycle();
        checkOutput("mid_owner", {busy, active_id}, {1'b1, 3'd3});
        reset_n = 1'b0;
        #1;
        check_reset_values();
        req = '0;
        repeat (2) step_cycle();
        reset_n = 1'b1;
        check_init_sequence();
        checkOutput("mid_no_done", done_pulses - done_before, 0);

        for (int i = 0; i < NUM_REQ; i++)
            dv[32*i +: 32] = 32'($urandom_range(0, 25));
        applyStimulus(4'b1111, dv, 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
